prog_loader: RTL and testbench

Writer side of the instruction memory that the core fetches from. It accepts a boot image as a valid/ready stream of 16-bit words and writes it into program memory starting at address 0. It then reads the whole image back and checks it against a checksum. The core is released through core_run only after a successful check, so the fetch unit never reads a partially loaded image.

---
 rtl/prog_loader_if.sv | 27 ++
 rtl/prog_loader.sv | 196 +++++++++++++++++++
 tb/tb_prog_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : prog_loader_if                                                    |
// | Brief  : boot-image stream and program-memory port of the loader           |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
interface prog_loader_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [15:0] address_mem;
    logic [15:0] data_mem;
    logic        wren_mem;
    logic [15:0] q_mem;

    modport master (
        input  in_valid, in_data, q_mem,
        output in_ready, address_mem, data_mem, wren_mem
    );

    modport slave (
        output in_valid, in_data, q_mem,
        input  in_ready, address_mem, data_mem, wren_mem
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : prog_loader                                                       |
// | Brief  : writes a checksummed boot image into program memory, reads it     |
// |          back, and releases the core only after a clean verification       |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module prog_loader #(
    parameter int DEPTH        = 65536,
    parameter int READ_LATENCY = 2
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    prog_loader_if.master    bus,
    input  wire logic        restart,
    output logic             core_run,
    output logic [1:0]       status,
    output logic [15:0]      load_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_VERIFY = 3'd3,
        S_RUN    = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam logic [16:0] c_DEPTH   = 17'(DEPTH);
    localparam logic [1:0]  c_ST_OK   = 2'd0;
    localparam logic [1:0]  c_ST_WSUM = 2'd1;
    localparam logic [1:0]  c_ST_RSUM = 2'd2;
    localparam logic [1:0]  c_ST_LEN  = 2'd3;

    state_t                  r_state;
    logic                    r_in_ready;
    logic [15:0]             r_addr;
    logic [15:0]             r_wdata;
    logic                    r_wren;
    logic                    r_core_run;
    logic [1:0]              r_status;
    logic [15:0]             r_load_count;
    logic [16:0]             r_len;
    logic [16:0]             r_cnt;
    logic [16:0]             r_rcnt;
    logic [15:0]             r_wsum;
    logic [15:0]             r_rsum;
    logic [15:0]             r_csum;
    logic                    r_rd_vld;
    logic [READ_LATENCY-1:0] r_pipe;

    logic        w_xfer;
    logic [16:0] w_len;
    logic [16:0] w_cnt_inc;
    logic        w_sample;

    assign w_xfer    = bus.in_valid && r_in_ready;
    assign w_len     = {1'b0, bus.in_data};
    assign w_cnt_inc = r_cnt + 17'd1;
    assign w_sample  = r_pipe[READ_LATENCY-1];

    // Tracks each verify read through the memory's fixed read latency.
    generate
        if (READ_LATENCY == 1) begin : g_pipe_1
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) r_pipe <= '0;
                else          r_pipe <= r_rd_vld;
            end
        end else begin : g_pipe_n
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) r_pipe <= '0;
                else          r_pipe <= {r_pipe[READ_LATENCY-2:0], r_rd_vld};
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wren       <= 1'b0;
            r_core_run   <= 1'b0;
            r_status     <= c_ST_OK;
            r_load_count <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_rcnt       <= '0;
            r_wsum       <= '0;
            r_rsum       <= '0;
            r_csum       <= '0;
            r_rd_vld     <= 1'b0;
        end else begin
            r_wren     <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_in_ready <= (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_CHECK);
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_len        <= w_len;
                        r_cnt        <= '0;
                        r_wsum       <= '0;
                        r_load_count <= '0;
                        if (w_len > c_DEPTH) begin
                            r_state    <= S_FAIL;
                            r_in_ready <= 1'b0;
                            r_status   <= c_ST_LEN;
                        end else if (w_len == 17'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_wren       <= 1'b1;
                        r_addr       <= r_cnt[15:0];
                        r_wdata      <= bus.in_data;
                        r_wsum       <= r_wsum + bus.in_data;
                        r_cnt        <= w_cnt_inc;
                        r_load_count <= r_load_count + 16'd1;
                        if (w_cnt_inc == r_len) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        r_csum     <= bus.in_data;
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_rcnt     <= '0;
                        r_rsum     <= '0;
                        if (r_wsum != bus.in_data) begin
                            r_state  <= S_FAIL;
                            r_status <= c_ST_WSUM;
                        end else begin
                            r_state <= S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    r_in_ready <= 1'b0;
                    if (r_cnt < r_len) begin
                        r_addr   <= r_cnt[15:0];
                        r_rd_vld <= 1'b1;
                        r_cnt    <= w_cnt_inc;
                    end
                    if (w_sample) begin
                        r_rsum <= r_rsum + bus.q_mem;
                        r_rcnt <= r_rcnt + 17'd1;
                    end else if ((r_rcnt == r_len) && (r_cnt == r_len)) begin
                        // Every read issued and returned; an empty image lands here at once.
                        if (r_rsum == r_csum) begin
                            r_state    <= S_RUN;
                            r_core_run <= 1'b1;
                            r_status   <= c_ST_OK;
                            r_addr     <= '0;
                        end else begin
                            r_state  <= S_FAIL;
                            r_status <= c_ST_RSUM;
                        end
                    end
                end
                S_RUN, S_FAIL: begin
                    r_in_ready <= 1'b0;
                    if (restart) begin
                        r_state      <= S_IDLE;
                        r_in_ready   <= 1'b1;
                        r_core_run   <= 1'b0;
                        r_status     <= c_ST_OK;
                        r_load_count <= '0;
                        r_wsum       <= '0;
                        r_rsum       <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.address_mem = r_addr;
    assign bus.data_mem    = r_wdata;
    assign bus.wren_mem    = r_wren;
    assign core_run        = r_core_run;
    assign status          = r_status;
    assign load_count      = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_prog_loader                                                    |
// | Brief  : randomized bench for prog_loader against an image-level model     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_prog_loader;
    localparam int DEPTH = 16;
    localparam int RL    = 2;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        restart = 1'b0;
    logic        core_run;
    logic [1:0]  status;
    logic [15:0] load_count;

    prog_loader_if bus ();

    prog_loader #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .restart    (restart),
        .core_run   (core_run),
        .status     (status),
        .load_count (load_count)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Program memory: registered address and registered output, two-cycle read.
    logic [15:0] mem [0:63];
    logic [15:0] r_a;
    logic        fill_req     = 1'b0;
    logic        corrupt_en   = 1'b0;
    logic [15:0] corrupt_addr = 16'd0;

    always @(posedge clock) begin
        if (fill_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'($urandom);
        end else if (bus.wren_mem) begin
            mem[bus.address_mem[5:0]] <= bus.data_mem;
        end
        r_a       <= bus.address_mem;
        bus.q_mem <= (corrupt_en && r_a == corrupt_addr) ? 16'h0000 : mem[r_a[5:0]];
    end

    // A write is due exactly one cycle after each accepted image word.
    logic mon_en     = 1'b0;
    logic data_phase = 1'b0;
    logic exp_wren;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) exp_wren <= 1'b0;
        else          exp_wren <= bus.in_valid && bus.in_ready && data_phase;
    end

    always @(negedge clock) begin
        if (mon_en && reset_n) check_val("wren_mem", 32'(bus.wren_mem), 32'(exp_wren));
    end

    function automatic void ref_outcome(input int n, input logic [15:0] w[$], input logic [15:0] c,
                                        input int cidx, output bit run, output logic [1:0] st);
        logic [15:0] ws = 16'd0;
        logic [15:0] rs = 16'd0;
        run = 1'b0;
        if (n > DEPTH) begin
            st = 2'd3;
            return;
        end
        foreach (w[i]) begin
            ws += w[i];
            rs += (i == cidx) ? 16'h0000 : w[i];
        end
        if (ws != c)      st = 2'd1;
        else if (rs != c) st = 2'd2;
        else begin
            st  = 2'd0;
            run = 1'b1;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_word(input logic [15:0] w, input bit dph);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        data_phase   = dph;
        while (!bus.in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check_val("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        data_phase   = 1'b0;
    endtask

    task automatic fill_mem();
        fill_req = 1'b1;
        @(negedge clock);
        fill_req = 1'b0;
    endtask

    task automatic run_image(input int n, input logic [15:0] w[$], input logic [15:0] c,
                             input bit throttle, input int cidx);
        bit          exp_run;
        logic [1:0]  exp_st;
        int          t = 0;
        fill_mem();
        corrupt_en   = (cidx >= 0);
        corrupt_addr = 16'(cidx);
        send_word(16'(n), 1'b0);
        if (n <= DEPTH) begin
            foreach (w[i]) begin
                send_word(w[i], 1'b1);
                if (throttle) @(negedge clock);
            end
            send_word(c, 1'b0);
        end
        ref_outcome(n, w, c, cidx, exp_run, exp_st);
        while (!(core_run || status != 2'd0) && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (t >= 400) check_val("outcome_timeout", 32'd0, 32'd1);
        check_val("core_run", 32'(core_run), 32'(exp_run));
        check_val("status", 32'(status), 32'(exp_st));
        check_val("load_count", 32'(load_count), (n > DEPTH) ? 32'd0 : 32'(n));
        check_val("in_ready_end", 32'(bus.in_ready), 32'd0);
        if (exp_run) check_val("address_run", 32'(bus.address_mem), 32'd0);
        if (n <= DEPTH) foreach (w[i]) check_val("image_word", 32'(mem[i]), 32'(w[i]));
        corrupt_en = 1'b0;
    endtask

    task automatic do_restart(input bit with_valid);
        restart      = 1'b1;
        bus.in_valid = with_valid;
        bus.in_data  = 16'd5;
        @(negedge clock);
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        check_val("restart_core_run", 32'(core_run), 32'd0);
        check_val("restart_status", 32'(status), 32'd0);
        check_val("restart_load_count", 32'(load_count), 32'd0);
        check_val("restart_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_val({tag, "_wren"}, 32'(bus.wren_mem), 32'd0);
        check_val({tag, "_addr"}, 32'(bus.address_mem), 32'd0);
        check_val({tag, "_data"}, 32'(bus.data_mem), 32'd0);
        check_val({tag, "_core_run"}, 32'(core_run), 32'd0);
        check_val({tag, "_status"}, 32'(status), 32'd0);
        check_val({tag, "_load_count"}, 32'(load_count), 32'd0);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] s;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'd0;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_val("idle_in_ready", 32'(bus.in_ready), 32'd1);
        mon_en = 1'b1;

        q = '{16'h1111, 16'h2222, 16'h0003};
        run_image(3, q, 16'h3336, 1'b0, -1);
        do_restart(1'b1);

        q = '{16'h0001, 16'h0002};
        run_image(2, q, 16'h0004, 1'b0, -1);
        do_restart(1'b0);

        q = '{16'h00AA, 16'h0055};
        run_image(2, q, 16'h00FF, 1'b0, 1);
        do_restart(1'b0);

        q = {};
        s = 16'd0;
        for (int i = 0; i < 4; i++) begin
            q.push_back(16'($urandom));
            s += q[i];
        end
        run_image(4, q, s, 1'b1, -1);
        do_restart(1'b0);

        q = {};
        run_image(0, q, 16'h0000, 1'b0, -1);
        do_restart(1'b0);

        run_image(DEPTH + 1, q, 16'h0000, 1'b0, -1);
        do_restart(1'b0);

        // Abort a load halfway with reset, then load a fresh image.
        fill_mem();
        mon_en = 1'b0;
        send_word(16'd4, 1'b0);
        send_word(16'h1234, 1'b1);
        send_word(16'h5678, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;
        q = '{16'hCAFE, 16'h0101, 16'hFFFF};
        run_image(3, q, 16'hCAFE + 16'h0101 + 16'hFFFF, 1'b0, -1);
        do_restart(1'b1);

        for (int it = 0; it < 25; it++) begin
            int n;
            int cidx;
            logic [15:0] c;
            n = $urandom_range(0, DEPTH + 2);
            q = {};
            s = 16'd0;
            for (int i = 0; i < n && n <= DEPTH; i++) begin
                q.push_back(16'($urandom));
                s += q[i];
            end
            c    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : s;
            cidx = (n > 0 && n <= DEPTH && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_image(n, q, c, 1'($urandom_range(0, 1)), cidx);
            do_restart(1'($urandom_range(0, 1)));
        end

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
